// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, round keys fetched
// from an external key-schedule store through rk_idx/rk_data in the same cycle.
module inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("inv_cipher_iter: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [0:127] r_state;
  logic [0:127] w_state_nxt;
  logic [3:0]   r_rnd;
  logic [3:0]   w_rnd_nxt;
  logic [0:127] w_inv_core;
  logic [0:127] w_ark;
  logic [0:127] w_imc;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] o;
    o = '0;
    case (b)
      8'h00: o = 8'h52; 8'h01: o = 8'h09; 8'h02: o = 8'h6a; 8'h03: o = 8'hd5; 8'h04: o = 8'h30; 8'h05: o = 8'h36; 8'h06: o = 8'ha5; 8'h07: o = 8'h38;
      8'h08: o = 8'hbf; 8'h09: o = 8'h40; 8'h0a: o = 8'ha3; 8'h0b: o = 8'h9e; 8'h0c: o = 8'h81; 8'h0d: o = 8'hf3; 8'h0e: o = 8'hd7; 8'h0f: o = 8'hfb;
      8'h10: o = 8'h7c; 8'h11: o = 8'he3; 8'h12: o = 8'h39; 8'h13: o = 8'h82; 8'h14: o = 8'h9b; 8'h15: o = 8'h2f; 8'h16: o = 8'hff; 8'h17: o = 8'h87;
      8'h18: o = 8'h34; 8'h19: o = 8'h8e; 8'h1a: o = 8'h43; 8'h1b: o = 8'h44; 8'h1c: o = 8'hc4; 8'h1d: o = 8'hde; 8'h1e: o = 8'he9; 8'h1f: o = 8'hcb;
      8'h20: o = 8'h54; 8'h21: o = 8'h7b; 8'h22: o = 8'h94; 8'h23: o = 8'h32; 8'h24: o = 8'ha6; 8'h25: o = 8'hc2; 8'h26: o = 8'h23; 8'h27: o = 8'h3d;
      8'h28: o = 8'hee; 8'h29: o = 8'h4c; 8'h2a: o = 8'h95; 8'h2b: o = 8'h0b; 8'h2c: o = 8'h42; 8'h2d: o = 8'hfa; 8'h2e: o = 8'hc3; 8'h2f: o = 8'h4e;
      8'h30: o = 8'h08; 8'h31: o = 8'h2e; 8'h32: o = 8'ha1; 8'h33: o = 8'h66; 8'h34: o = 8'h28; 8'h35: o = 8'hd9; 8'h36: o = 8'h24; 8'h37: o = 8'hb2;
      8'h38: o = 8'h76; 8'h39: o = 8'h5b; 8'h3a: o = 8'ha2; 8'h3b: o = 8'h49; 8'h3c: o = 8'h6d; 8'h3d: o = 8'h8b; 8'h3e: o = 8'hd1; 8'h3f: o = 8'h25;
      8'h40: o = 8'h72; 8'h41: o = 8'hf8; 8'h42: o = 8'hf6; 8'h43: o = 8'h64; 8'h44: o = 8'h86; 8'h45: o = 8'h68; 8'h46: o = 8'h98; 8'h47: o = 8'h16;
      8'h48: o = 8'hd4; 8'h49: o = 8'ha4; 8'h4a: o = 8'h5c; 8'h4b: o = 8'hcc; 8'h4c: o = 8'h5d; 8'h4d: o = 8'h65; 8'h4e: o = 8'hb6; 8'h4f: o = 8'h92;
      8'h50: o = 8'h6c; 8'h51: o = 8'h70; 8'h52: o = 8'h48; 8'h53: o = 8'h50; 8'h54: o = 8'hfd; 8'h55: o = 8'hed; 8'h56: o = 8'hb9; 8'h57: o = 8'hda;
      8'h58: o = 8'h5e; 8'h59: o = 8'h15; 8'h5a: o = 8'h46; 8'h5b: o = 8'h57; 8'h5c: o = 8'ha7; 8'h5d: o = 8'h8d; 8'h5e: o = 8'h9d; 8'h5f: o = 8'h84;
      8'h60: o = 8'h90; 8'h61: o = 8'hd8; 8'h62: o = 8'hab; 8'h63: o = 8'h00; 8'h64: o = 8'h8c; 8'h65: o = 8'hbc; 8'h66: o = 8'hd3; 8'h67: o = 8'h0a;
      8'h68: o = 8'hf7; 8'h69: o = 8'he4; 8'h6a: o = 8'h58; 8'h6b: o = 8'h05; 8'h6c: o = 8'hb8; 8'h6d: o = 8'hb3; 8'h6e: o = 8'h45; 8'h6f: o = 8'h06;
      8'h70: o = 8'hd0; 8'h71: o = 8'h2c; 8'h72: o = 8'h1e; 8'h73: o = 8'h8f; 8'h74: o = 8'hca; 8'h75: o = 8'h3f; 8'h76: o = 8'h0f; 8'h77: o = 8'h02;
      8'h78: o = 8'hc1; 8'h79: o = 8'haf; 8'h7a: o = 8'hbd; 8'h7b: o = 8'h03; 8'h7c: o = 8'h01; 8'h7d: o = 8'h13; 8'h7e: o = 8'h8a; 8'h7f: o = 8'h6b;
      8'h80: o = 8'h3a; 8'h81: o = 8'h91; 8'h82: o = 8'h11; 8'h83: o = 8'h41; 8'h84: o = 8'h4f; 8'h85: o = 8'h67; 8'h86: o = 8'hdc; 8'h87: o = 8'hea;
      8'h88: o = 8'h97; 8'h89: o = 8'hf2; 8'h8a: o = 8'hcf; 8'h8b: o = 8'hce; 8'h8c: o = 8'hf0; 8'h8d: o = 8'hb4; 8'h8e: o = 8'he6; 8'h8f: o = 8'h73;
      8'h90: o = 8'h96; 8'h91: o = 8'hac; 8'h92: o = 8'h74; 8'h93: o = 8'h22; 8'h94: o = 8'he7; 8'h95: o = 8'had; 8'h96: o = 8'h35; 8'h97: o = 8'h85;
      8'h98: o = 8'he2; 8'h99: o = 8'hf9; 8'h9a: o = 8'h37; 8'h9b: o = 8'he8; 8'h9c: o = 8'h1c; 8'h9d: o = 8'h75; 8'h9e: o = 8'hdf; 8'h9f: o = 8'h6e;
      8'ha0: o = 8'h47; 8'ha1: o = 8'hf1; 8'ha2: o = 8'h1a; 8'ha3: o = 8'h71; 8'ha4: o = 8'h1d; 8'ha5: o = 8'h29; 8'ha6: o = 8'hc5; 8'ha7: o = 8'h89;
      8'ha8: o = 8'h6f; 8'ha9: o = 8'hb7; 8'haa: o = 8'h62; 8'hab: o = 8'h0e; 8'hac: o = 8'haa; 8'had: o = 8'h18; 8'hae: o = 8'hbe; 8'haf: o = 8'h1b;
      8'hb0: o = 8'hfc; 8'hb1: o = 8'h56; 8'hb2: o = 8'h3e; 8'hb3: o = 8'h4b; 8'hb4: o = 8'hc6; 8'hb5: o = 8'hd2; 8'hb6: o = 8'h79; 8'hb7: o = 8'h20;
      8'hb8: o = 8'h9a; 8'hb9: o = 8'hdb; 8'hba: o = 8'hc0; 8'hbb: o = 8'hfe; 8'hbc: o = 8'h78; 8'hbd: o = 8'hcd; 8'hbe: o = 8'h5a; 8'hbf: o = 8'hf4;
      8'hc0: o = 8'h1f; 8'hc1: o = 8'hdd; 8'hc2: o = 8'ha8; 8'hc3: o = 8'h33; 8'hc4: o = 8'h88; 8'hc5: o = 8'h07; 8'hc6: o = 8'hc7; 8'hc7: o = 8'h31;
      8'hc8: o = 8'hb1; 8'hc9: o = 8'h12; 8'hca: o = 8'h10; 8'hcb: o = 8'h59; 8'hcc: o = 8'h27; 8'hcd: o = 8'h80; 8'hce: o = 8'hec; 8'hcf: o = 8'h5f;
      8'hd0: o = 8'h60; 8'hd1: o = 8'h51; 8'hd2: o = 8'h7f; 8'hd3: o = 8'ha9; 8'hd4: o = 8'h19; 8'hd5: o = 8'hb5; 8'hd6: o = 8'h4a; 8'hd7: o = 8'h0d;
      8'hd8: o = 8'h2d; 8'hd9: o = 8'he5; 8'hda: o = 8'h7a; 8'hdb: o = 8'h9f; 8'hdc: o = 8'h93; 8'hdd: o = 8'hc9; 8'hde: o = 8'h9c; 8'hdf: o = 8'hef;
      8'he0: o = 8'ha0; 8'he1: o = 8'he0; 8'he2: o = 8'h3b; 8'he3: o = 8'h4d; 8'he4: o = 8'hae; 8'he5: o = 8'h2a; 8'he6: o = 8'hf5; 8'he7: o = 8'hb0;
      8'he8: o = 8'hc8; 8'he9: o = 8'heb; 8'hea: o = 8'hbb; 8'heb: o = 8'h3c; 8'hec: o = 8'h83; 8'hed: o = 8'h53; 8'hee: o = 8'h99; 8'hef: o = 8'h61;
      8'hf0: o = 8'h17; 8'hf1: o = 8'h2b; 8'hf2: o = 8'h04; 8'hf3: o = 8'h7e; 8'hf4: o = 8'hba; 8'hf5: o = 8'h77; 8'hf6: o = 8'hd6; 8'hf7: o = 8'h26;
      8'hf8: o = 8'he1; 8'hf9: o = 8'h69; 8'hfa: o = 8'h14; 8'hfb: o = 8'h63; 8'hfc: o = 8'h55; 8'hfd: o = 8'h21; 8'hfe: o = 8'h0c; 8'hff: o = 8'h7d;
    endcase
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates right by r positions.
  function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[8*(r+4*c) +: 8] = inv_sbox(s[8*(r+4*((c+4-r)%4)) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        a[i]  = s[8*(4*c+i) +: 8];
        x2[i] = xtime(a[i]);
        x4[i] = xtime(x2[i]);
        x8[i] = xtime(x4[i]);
        m9[i] = x8[i] ^ a[i];
        mb[i] = x8[i] ^ x2[i] ^ a[i];
        md[i] = x8[i] ^ x4[i] ^ a[i];
        me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      o[8*(4*c+0) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[8*(4*c+1) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[8*(4*c+2) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[8*(4*c+3) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  assign w_inv_core = inv_shift_sub(r_state);
  assign w_ark      = w_inv_core ^ rk_data;
  assign w_imc      = inv_mix_columns(w_ark);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_rnd   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    rk_idx      = '0;
    unique case (r_fsm)
      S_IDLE: begin
        rk_idx = 4'(NR);
        if (in_valid) begin
          w_state_nxt = in_data ^ rk_data;
          w_rnd_nxt   = 4'(NR - 1);
          w_fsm_nxt   = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx      = r_rnd;
        w_state_nxt = w_imc;
        w_rnd_nxt   = r_rnd - 4'd1;
        if (r_rnd == 4'd1) w_fsm_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_state_nxt = w_ark;
        w_fsm_nxt   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_data  = (r_fsm == S_DONE) ? r_state : '0;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Scoreboard bench for inv_cipher_iter: NR=10 and NR=14 instances, a key-schedule store,
// and a byte-level AES reference built from GF(2^8) arithmetic.
module tb_inv_cipher_iter;

  typedef logic [15:0][127:0] rks_t;

  logic         clk = 1'b0;
  logic         rst;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  int           n_hs10 = 0;
  int           n_hs14 = 0;

  logic         in_valid10, in_ready10, out_valid10, out_ready10, busy10;
  logic [127:0] in_data10, rk_data10, out_data10;
  logic [3:0]   rk_idx10;
  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] in_data14, rk_data14, out_data14;
  logic [3:0]   rk_idx14;

  rks_t         rks10;
  rks_t         rks14;
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] exp_q   [$];
  logic [127:0] exp14_q [$];

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk_data10 = rks10[rk_idx10];
  assign rk_data14 = rks14[rk_idx14];

  inv_cipher_iter #(.NR(10)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
    .rk_idx(rk_idx10), .rk_data(rk_data10), .out_valid(out_valid10), .out_ready(out_ready10),
    .out_data(out_data10), .busy(busy10)
  );

  inv_cipher_iter #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data14),
    .rk_idx(rk_idx14), .rk_data(rk_data14), .out_valid(out_valid14), .out_ready(out_ready14),
    .out_data(out_data14), .busy(busy14)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s ^= r;
      end
      s ^= 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic rks_t expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rks_t        o = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input rks_t rks, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] k, o;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    k = rks[nr];
    for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ k[127-8*n -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      k = rks[rd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = isbox_t[s[r+4*((c+4-r)%4)]];
      for (int n = 0; n < 16; n++) t[n] ^= k[127-8*n -: 8];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) begin
          if (rd == 0) s[4*c+i] = t[4*c+i];
          else begin
            s[4*c+i] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c+i] ^= gmul(t[4*c+j], coef[(j-i+4)%4]);
          end
        end
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid10 && out_ready10) begin
      n_hs10++;
      if (exp_q.size() == 0) check("sb10_unexpected", out_data10, 128'hx);
      else check("sb10_plaintext", out_data10, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid14 && out_ready14) begin
      n_hs14++;
      if (exp14_q.size() == 0) check("sb14_unexpected", out_data14, 128'hx);
      else check("sb14_plaintext", out_data14, exp14_q.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send10(input logic [127:0] ct);
    bit ok = 1'b0;
    in_valid10 = 1'b1;
    in_data10  = ct;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready10) begin ok = 1'b1; break; end
    end
    check("accept10", 128'(ok), 128'd1);
    exp_q.push_back(ref_decrypt(ct, rks10, 10));
    @(posedge clk); #1;
    in_valid10 = 1'b0;
  endtask

  task automatic wait_hs10(input int target, input bit rnd_ready);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (n_hs10 >= target) begin ok = 1'b1; break; end
      if (rnd_ready) out_ready10 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("handshake10_wait", 128'(ok), 128'd1);
    out_ready10 = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, last, base;
    bit ok;
    logic [127:0] ct, exp;
    rst = 1'b1;
    in_valid10 = 1'b0; in_data10 = '0; out_ready10 = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
    build_sbox();
    rks10 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    rks14 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready10), 128'd1);
    check("rst_out_valid", 128'(out_valid10), 128'd0);
    check("rst_busy", 128'(busy10), 128'd0);
    check("rst_out_data", out_data10, 128'd0);
    check("rst_rk_idx", 128'(rk_idx10), 128'd10);
    check("rst_rk_idx14", 128'(rk_idx14), 128'd14);
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 C.1: rk_idx sequence, initial AddRoundKey, exact latency.
    out_ready10 = 1'b1; in_valid10 = 1'b1; in_data10 = CT1;
    @(negedge clk);
    check("c1_accept_ready", 128'(in_ready10), 128'd1);
    check("c1_rk_idx_10", 128'(rk_idx10), 128'd10);
    exp_q.push_back(PT);
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    check("c1_initial_ark", u_dut.r_state, CT1 ^ K10);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("c1_rk_idx_%0d", 10 - k), 128'(rk_idx10), 128'(10 - k));
      check("c1_no_early_valid", 128'(out_valid10), 128'd0);
    end
    @(negedge clk);
    check("c1_valid_at_10", 128'(out_valid10), 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("c1_idle_after", 128'(in_ready10), 128'd1);
    check("c1_busy_after", 128'(busy10), 128'd0);
    @(posedge clk); #1;

    // Random key for the remaining NR=10 traffic.
    rks10 = expand_key({rnd128(), 128'h0}, 4, 10);

    // Backpressure: out_ready low for several DONE cycles with in_valid asserted.
    out_ready10 = 1'b0;
    ct = rnd128();
    exp = ref_decrypt(ct, rks10, 10);
    send10(ct);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid10) begin ok = 1'b1; break; end
    end
    check("bp_reach_done", 128'(ok), 128'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 128'(out_valid10), 128'd1);
      check("bp_data_stable", out_data10, exp);
      check("bp_in_ready_low", 128'(in_ready10), 128'd0);
      @(posedge clk); #1;
      in_valid10 = 1'b1; in_data10 = rnd128();
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid10 = 1'b0; out_ready10 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_after_hs", 128'(in_ready10), 128'd1);
    check("bp_valid_dropped", 128'(out_valid10), 128'd0);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high: accepts every 12 cycles.
    base = n_hs10;
    out_ready10 = 1'b1; in_valid10 = 1'b1; in_data10 = rnd128();
    last = 0;
    for (int b = 0; b < 6; b++) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (in_ready10) begin ok = 1'b1; break; end
      end
      check("b2b_accept", 128'(ok), 128'd1);
      exp_q.push_back(ref_decrypt(in_data10, rks10, 10));
      if (b > 0) check("b2b_gap", 128'(cyc - last), 128'd12);
      last = cyc;
      @(posedge clk); #1;
      in_data10 = rnd128();
    end
    in_valid10 = 1'b0;
    wait_hs10(base + 6, 1'b0);

    // Reset while rnd==5: block discarded, no stale output afterwards.
    send10(rnd128());
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_rnd5", 128'(u_dut.r_rnd), 128'd5);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 128'(in_ready10), 128'd1);
    check("rst_mid_out_valid", 128'(out_valid10), 128'd0);
    check("rst_mid_busy", 128'(busy10), 128'd0);
    @(posedge clk); #1;
    base = n_hs10;
    send10(rnd128());
    wait_hs10(base + 1, 1'b0);

    // Random traffic with idle gaps and random output backpressure.
    for (int b = 0; b < 12; b++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      base = n_hs10;
      send10(rnd128());
      wait_hs10(base + 1, 1'b1);
    end

    // NR=14, FIPS-197 C.3, then one random block.
    out_ready14 = 1'b1; in_valid14 = 1'b1; in_data14 = CT3;
    @(negedge clk);
    check("c3_accept_ready", 128'(in_ready14), 128'd1);
    exp14_q.push_back(PT);
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid14) break;
      @(posedge clk); #1;
      lat = k;
    end
    check("c3_latency", 128'(lat), 128'd14);
    @(posedge clk); #1;
    ct = rnd128();
    in_valid14 = 1'b1; in_data14 = ct;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready14) begin ok = 1'b1; break; end
    end
    check("c3_rand_accept", 128'(ok), 128'd1);
    exp14_q.push_back(ref_decrypt(ct, rks14, 14));
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (n_hs14 >= 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("handshake14_wait", 128'(ok), 128'd1);

    repeat (3) @(posedge clk);
    check("sb10_drained", 128'(exp_q.size()), 128'd0);
    check("sb14_drained", 128'(exp14_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
